// File: rtl/ifu_fetch_ctrl.sv
// Fetch-stage controller: PC register, in-order fetch buffer to decode, redirect/flush, halt after faulting fetch.
// Build option IFU_SKID_EN: two-entry buffer that decouples fetch from id_ready_i; otherwise one entry.
module ifu_fetch_ctrl #(
    parameter int                PC_WIDTH    = 32,
    parameter int                INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    pc_o,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   pc_misalign_i,
    input  logic                   bus_err_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    input  logic                   id_ready_i,
    output logic                   id_valid_o,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    output logic [PC_WIDTH-1:0]    id_pc_o,
    output logic [1:0]             id_exc_o
);

`ifdef IFU_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam logic [INSTR_WIDTH-1:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {S_FETCH = 1'b0, S_HALT = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    r_buf_pc    [2];
    logic [INSTR_WIDTH-1:0] r_buf_instr [2];
    logic [1:0]             r_buf_exc   [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    logic [1:0]             w_exc;
    logic                   w_space;
    logic                   w_push;
    logic                   w_pop;

    assign w_exc = {bus_err_i, pc_misalign_i};
    assign pc_o  = r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_push && (w_exc != 2'b00)) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                if (redirect_i) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_HALT;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Without the skid entry a same-cycle pop frees the single slot, so ready feeds fetch directly.
    always_comb begin
        if (DEPTH == 2) begin
            w_space = (r_count < 2'd2);
        end else begin
            w_space = (r_count == 2'd0) || id_ready_i;
        end
        w_push = (r_state == S_FETCH) && !redirect_i && w_space;
        w_pop  = (r_count != 2'd0) && id_ready_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_buf_pc[i]    <= '0;
                r_buf_instr[i] <= NOP;
                r_buf_exc[i]   <= 2'b00;
            end
        end else if (redirect_i) begin
            r_pc     <= redirect_pc_i;
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf_pc[r_wr_ptr]    <= r_pc;
                r_buf_instr[r_wr_ptr] <= instr_i;
                r_buf_exc[r_wr_ptr]   <= w_exc;
                r_wr_ptr              <= (DEPTH == 2) ? ~r_wr_ptr : 1'b0;
                if (w_exc == 2'b00) begin
                    r_pc <= r_pc + PC_WIDTH'(4);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= (DEPTH == 2) ? ~r_rd_ptr : 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Empty buffer presents a NOP at PC 0 so decode never sees stale data.
    always_comb begin
        if (r_count != 2'd0) begin
            id_valid_o = 1'b1;
            id_instr_o = r_buf_instr[r_rd_ptr];
            id_pc_o    = r_buf_pc[r_rd_ptr];
            id_exc_o   = r_buf_exc[r_rd_ptr];
        end else begin
            id_valid_o = 1'b0;
            id_instr_o = NOP;
            id_pc_o    = '0;
            id_exc_o   = 2'b00;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl against a queue-based fetch model.
module tb_ifu_fetch_ctrl;

`ifdef IFU_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  exc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        pc_misalign_i;
    logic        bus_err_i;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [1:0]  id_exc_o;

    logic        berr_force = 1'b0;
    logic        berr_en    = 1'b0;
    logic [31:0] berr_pc    = 32'h0;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_halt;
    int          n_checks = 0;
    int          n_errors = 0;

    ifu_fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_o(pc_o), .instr_i(instr_i),
        .pc_misalign_i(pc_misalign_i), .bus_err_i(bus_err_i),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .id_ready_i(id_ready), .id_valid_o(id_valid_o),
        .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_exc_o(id_exc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
    endfunction

    function automatic logic berr_f(input logic [31:0] a);
        return berr_force | (berr_en && (a == berr_pc));
    endfunction

    assign instr_i       = mem_f(pc_o);
    assign pc_misalign_i = (pc_o[1:0] != 2'b00);
    assign bus_err_i     = berr_f(pc_o);

    wire [98:0] obs = {pc_o, id_valid_o, id_instr_o, id_pc_o, id_exc_o};

    function automatic logic [98:0] exp_vec();
        if (q.size() == 0) return {m_pc, 1'b0, 32'h0000_0013, 32'h0, 2'b00};
        return {m_pc, 1'b1, q[0].instr, q[0].pc, q[0].exc};
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc   = 32'h0;
        m_halt = 1'b0;
    endtask

    // One clock of the fetch rules: pop head, then push the fetched word if there is room.
    task automatic model_edge();
        bit pop, space;
        logic [1:0] exc;
        pop = (q.size() > 0) && id_ready;
        if (redirect) begin
            q.delete();
            m_pc   = redirect_pc;
            m_halt = 1'b0;
        end else begin
            if (SKID) space = (q.size() < 2);
            else      space = (q.size() == 0) || id_ready;
            if (pop) void'(q.pop_front());
            if (!m_halt && space) begin
                exc = {berr_f(m_pc), m_pc[1:0] != 2'b00};
                q.push_back({m_pc, mem_f(m_pc), exc});
                if (exc == 2'b00) m_pc = m_pc + 32'd4;
                else              m_halt = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        model_reset();
        repeat (2) cycle();
        n_checks++;
        if (obs !== exp_vec()) begin
            n_errors++; $display("FAIL reset_state: got %h want %h", obs, exp_vec());
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL first_fetch[%0d]: got %h want %h", i, obs, exp_vec());
            end
            n_checks++;
            if (id_pc_o !== 32'(i * 4) || id_valid_o !== 1'b1) begin
                n_errors++; $display("FAIL first_fetch_pc[%0d]: got pc %h valid %b want pc %h valid 1", i, id_pc_o, id_valid_o, 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL stall[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if ((pc_o - id_pc_o) !== (SKID ? 32'd8 : 32'd4) || id_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL stall_depth: got pc_o %h head %h want gap %0d", pc_o, id_pc_o, SKID ? 8 : 4);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL release[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0;
        repeat (3) cycle();
        redirect = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1;
        cycle();
        redirect = 1'b0;
        n_checks++;
        if (id_valid_o !== 1'b0 || pc_o !== 32'h100) begin
            n_errors++; $display("FAIL redirect_flush: got valid %b pc_o %h want valid 0 pc_o 00000100", id_valid_o, pc_o);
        end
        cycle();
        n_checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h100 || obs !== exp_vec()) begin
            n_errors++; $display("FAIL redirect_target: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h102; id_ready = 1'b1;
        cycle();
        redirect = 1'b0;
        cycle();
        n_checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h102 || id_exc_o !== 2'b01) begin
            n_errors++; $display("FAIL misalign_entry: got valid %b pc %h exc %b want 1 00000102 01", id_valid_o, id_pc_o, id_exc_o);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (id_valid_o !== 1'b0 || pc_o !== 32'h102 || obs !== exp_vec()) begin
                n_errors++; $display("FAIL misalign_halt[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_bus_err();
        berr_en = 1'b1; berr_pc = 32'h8;
        redirect = 1'b1; redirect_pc = 32'h0; id_ready = 1'b1;
        cycle();
        redirect = 1'b0;
        repeat (3) cycle();
        n_checks++;
        if (id_pc_o !== 32'h8 || id_exc_o !== 2'b10 || obs !== exp_vec()) begin
            n_errors++; $display("FAIL bus_err_entry: got %h want %h", obs, exp_vec());
        end
        repeat (3) cycle();
        n_checks++;
        if (id_valid_o !== 1'b0 || pc_o !== 32'h8) begin
            n_errors++; $display("FAIL bus_err_halt: got valid %b pc_o %h want 0 00000008", id_valid_o, pc_o);
        end
        berr_en = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0;
        cycle();
        redirect = 1'b0;
        cycle();
        n_checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || pc_o !== 32'h4) begin
            n_errors++; $display("FAIL bus_err_resume: got valid %b pc %h pc_o %h want 1 00000000 00000004", id_valid_o, id_pc_o, pc_o);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; id_ready = 1'b1;
        cycle();
        redirect = 1'b0;
        cycle();
        n_checks++;
        if (pc_o !== 32'h0 || id_pc_o !== 32'hFFFF_FFFC || id_exc_o !== 2'b00) begin
            n_errors++; $display("FAIL pc_wrap: got pc_o %h head %h exc %b want 00000000 fffffffc 00", pc_o, id_pc_o, id_exc_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_ready    = ($urandom_range(0, 3) != 0);
            berr_force  = ($urandom_range(0, 40) == 0);
            redirect    = ($urandom_range(0, 12) == 0);
            redirect_pc = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255) & ($urandom_range(0, 5) == 0 ? 32'hFF : 32'hFC));
            cycle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        berr_force = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_async_reset();
        redirect = 1'b1; redirect_pc = 32'h40; id_ready = 1'b0;
        cycle();
        redirect = 1'b0;
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (id_valid_o !== 1'b0 || pc_o !== 32'h0 || id_instr_o !== 32'h0000_0013) begin
            n_errors++; $display("FAIL async_reset: got valid %b pc_o %h instr %h want 0 00000000 00000013", id_valid_o, pc_o, id_instr_o);
        end
        model_reset();
        cycle();
        rst = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL after_reset[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_misalign();
        test_bus_err();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Fetch-stage controller that drives the fetch PC into the combinational instruction-memory read port and collects the returned instruction, PC and fetch exceptions into a small in-order buffer feeding decode over a valid/ready handshake. It owns the PC register, sequential PC increment, redirect/flush from execute, and halting of fetch after a faulting fetch. It sits between the branch/trap redirect logic in EX and the IF/ID boundary.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_o`  out  `PC_WIDTH` (32)  fetch PC to instruction memory; registered.
- `instr_i`  in  `INSTR_WIDTH` (32)  instruction read at `pc_o`, same cycle.
- `pc_misalign_i`  in  1  fetch PC not 4-byte aligned, same cycle.
- `bus_err_i`  in  1  fetch bus error, same cycle.
- `redirect_i`  in  1  flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i`  in  32  redirect target.
- `id_ready_i`  in  1  decode accepts head entry.
- `id_valid_o`  out  1  head entry valid.
- `id_instr_o`  out  32  head instruction.
- `id_pc_o`  out  32  head PC.
- `id_exc_o`  out  2  head exception: bit0 misalign, bit1 bus error.

## Operation
- State: `pc_q`, buffer (DEPTH entries of {pc, instr, exc}, circular, rd/wr pointers, count), FSM {FETCH, HALT}.
- Reset (async): `pc_q`=RESET_PC, count=0, pointers=0, FSM=FETCH. Outputs: `pc_o`=RESET_PC, `id_valid_o`=0, `id_instr_o`=32'h0000_0013 (NOP), `id_pc_o`=0, `id_exc_o`=0.
- `fetch_en` = FSM==FETCH and not `redirect_i` and buffer-space condition (see Configuration).
- On `fetch_en`: push {`pc_q`, `instr_i`, {`bus_err_i`,`pc_misalign_i`}}. If pushed exc==0: `pc_q` <= `pc_q`+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0). If exc!=0: `pc_q` holds, FSM -> HALT.
- HALT: no fetch; buffer drains normally; leaves only via redirect (or reset).
- Pop: `id_valid_o` && `id_ready_i`; advance read pointer.
- Push and pop in same cycle: count unchanged, order preserved.
- `redirect_i` (highest priority, any state): count=0, pointers=0, `pc_q`<=`redirect_pc_i`, FSM->FETCH, no push; any same-cycle pop handshake is void (entry discarded regardless).
- Misaligned redirect target: next cycle pushes entry with exc=2'b01 then HALT; no check on `redirect_pc_i` itself.
- Empty: `id_valid_o`=0, outputs take the reset values above. Non-empty: outputs show head entry, stable until popped or flushed.
- `instr_i` pushed as-is even when exc!=0; decode must honour `id_exc_o`.

## Timing
- `pc_o` valid from clock edge; memory read and exception flags combinational in same cycle.
- Fetch to `id_valid_o`: 1 cycle (entry visible cycle after push).
- First fetch: first rising edge with `rst` low pushes RESET_PC entry; `id_valid_o`=1 next cycle.
- Redirect asserted cycle N: `pc_o`=target in N+1, target entry `id_valid_o` in N+2; `id_valid_o`=0 in N+1.
- Steady state with `id_ready_i`=1: one instruction per cycle, PCs consecutive +4.
- Reset mid-operation: buffer contents lost immediately, outputs to reset values asynchronously.

## Configuration
- `IFU_SKID_EN` defined: DEPTH=2; space condition = count<2; `pc_o`/fetch independent of `id_ready_i` (no combinational ready->PC path); full throughput with count steady at 1.
- Not defined: DEPTH=1; space condition = count==0 or `id_ready_i` (pop frees slot same cycle); full throughput with combinational `id_ready_i`->fetch path.

## Test plan
- Reset, RESET_PC=0, `id_ready_i`=1, memory words at 0,4,8 -> `id_pc_o` 0,4,8 on consecutive cycles from 1 cycle after reset release, `id_valid_o` continuous.
- `id_ready_i`=0 for 5 cycles -> with `IFU_SKID_EN` 2 entries buffered (count=2), `pc_o` stalls at 8; without, 1 entry, `pc_o` stalls at 4; release -> no entry lost or duplicated.
- `redirect_i` with target 32'h100 while buffer full -> `id_valid_o`=0 next cycle, then `id_pc_o`=32'h100; flushed entries never popped.
- Redirect to 32'h102 -> one entry pc=32'h102, `id_exc_o`=2'b01, then `pc_o` frozen at 32'h102 and no further valid entries until next redirect.
- `bus_err_i`=1 at pc 32'h8 -> entry exc=2'b10, HALT; redirect to 0 resumes fetch at 0.
- `pc_q`=32'hFFFF_FFFC, no fault -> next `pc_o`=0; assert `rst` mid-stream -> `id_valid_o`=0 and `pc_o`=RESET_PC without a clock edge.
